// File: rtl/dir_seq_pkg.sv
// Shared types and constants for the timed direction sequencer.
// Holds the channel mode encoding and the prescale derivation.
package dir_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_TOGGLE   = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_HOLD_REV = 2'b11
    } mode_t;

    function automatic int unsigned calc_prescale(input int unsigned clk_hz,
                                                  input int unsigned tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/dir_sequencer_if.sv
// Run-time configuration port of the direction sequencer (valid/ready).
// master drives a request, slave (the sequencer) returns cfg_ready.
interface dir_sequencer_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned CW  = 10
);
    import dir_seq_pkg::*;

    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    mode_t          cfg_mode;
    logic [CW-1:0]  cfg_period;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_period,
        output cfg_ready
    );

endinterface

// File: rtl/dir_seq_chan.sv
// One direction channel: counts base ticks and drives a single direction line.
// A config apply always overrides a terminal event landing on the same edge.
module dir_seq_chan
    import dir_seq_pkg::*;
#(
    parameter int unsigned CW = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tick_i,
    input  logic          apply_i,
    input  mode_t         mode_i,
    input  logic [CW-1:0] period_i,
    output logic          dir_o,
    output logic          flip_pulse_o,
    output logic          busy_o
);

    mode_t         mode_q;
    logic [CW-1:0] per_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] last;
    logic          dir_q;
    logic          flip_q;
    logic          running;

    // Period 0 behaves as period 1, so the terminal count is 0 in both cases.
    assign last    = (per_q == '0) ? '0 : per_q - CW'(1);
    assign running = (mode_q == MODE_TOGGLE) || (mode_q == MODE_ONESHOT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_OFF;
            per_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b1;
            flip_q <= 1'b0;
        end else begin
            flip_q <= 1'b0;
            if (apply_i) begin
                mode_q <= mode_i;
                per_q  <= period_i;
                cnt_q  <= '0;
                unique case (mode_i)
                    MODE_OFF: begin
                        dir_q  <= 1'b1;
                        flip_q <= ~dir_q;
                    end
                    MODE_TOGGLE: begin
                        dir_q <= dir_q;
                    end
                    MODE_ONESHOT, MODE_HOLD_REV: begin
                        dir_q  <= 1'b0;
                        flip_q <= dir_q;
                    end
                endcase
            end else if (tick_i && running) begin
                if (cnt_q == last) begin
                    cnt_q  <= '0;
                    flip_q <= 1'b1;
                    if (mode_q == MODE_ONESHOT) begin
                        dir_q  <= 1'b1;
                        mode_q <= MODE_OFF;
                    end else begin
                        dir_q <= ~dir_q;
                    end
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign dir_o        = dir_q;
    assign flip_pulse_o = flip_q;
    assign busy_o       = running;

endmodule

// File: rtl/dir_sequencer.sv
// Multi-channel timed direction sequencer: shared prescaler, config handshake
// and per-channel decode feeding one dir_seq_chan per direction line.
module dir_sequencer
    import dir_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned NCH     = 2,
    parameter int unsigned CW      = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    dir_sequencer_if.slave       cfg,
    output logic [NCH-1:0]       dir_o,
    output logic [NCH-1:0]       flip_pulse_o,
    output logic [NCH-1:0]       busy_o,
    output logic                 tick_o
);

    localparam int unsigned PRESCALE = calc_prescale(CLK_HZ, TICK_HZ);
    localparam int unsigned PW       = $clog2(PRESCALE);
    localparam int unsigned CHW      = (NCH > 1) ? $clog2(NCH) : 1;

    logic [PW-1:0]  presc_q;
    logic           cfg_ready_q;
    logic           accept;
    logic           wrap;
    logic [NCH-1:0] apply;

    assign wrap   = (presc_q == PW'(PRESCALE - 1));
    assign tick_o = en_i && wrap;
    assign accept = cfg.cfg_valid && cfg_ready_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q     <= '0;
            cfg_ready_q <= 1'b0;
        end else begin
            if (en_i) begin
                presc_q <= wrap ? '0 : presc_q + PW'(1);
            end
            // Single config register: one bubble after every accept.
            cfg_ready_q <= ~accept;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign apply[i] = accept && (cfg.cfg_ch == CHW'(i));

        dir_seq_chan #(
            .CW (CW)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .tick_i       (tick_o),
            .apply_i      (apply[i]),
            .mode_i       (cfg.cfg_mode),
            .period_i     (cfg.cfg_period),
            .dir_o        (dir_o[i]),
            .flip_pulse_o (flip_pulse_o[i]),
            .busy_o       (busy_o[i])
        );
    end

endmodule
